// File: rtl/layer_stream_host_pkg.sv
// Shared types and helpers for the layer stream host and its counters.
// Used by layer_stream_host and stream_word_counter.
package layer_stream_pkg;

    // Transaction phases of the host.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of an index that must be able to hold the values 0..k.
    function automatic int idx_width(input int k);
        return (k < 1) ? 1 : $clog2(k + 1);
    endfunction

endpackage

// File: rtl/layer_stream_host_word_counter.sv
// Word index counter for one stream direction.
// Clears on clr, advances on inc; 'last' flags the increment that moves
// the final word (index K-1) so the caller can end its phase.
module stream_word_counter
    import layer_stream_pkg::*;
#(
    parameter int K = 3,
    parameter int W = idx_width(K)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         last
);

    logic [W-1:0] idx_reg;

    // Index register: clear has priority so a new transaction always starts at word 0.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            idx_reg <= '0;
        end else if (inc) begin
            idx_reg <= idx_reg + W'(1);
        end
    end

    assign idx  = idx_reg;
    assign last = inc && (idx_reg == W'(K - 1));

endmodule

// File: rtl/layer_stream_host.sv
// Host-side driver for a streaming layer block.
// Captures an N-word vector, streams it out on tx_*, then collects M result
// words on rx_* into a parallel result and pulses done.
// Optional build macro LAYER_STREAM_HOST_RX_THROTTLE_EN: when defined, rx_ready
// alternates 0,1,0,1,... during RECV to exercise the layer's back-pressure path;
// otherwise rx_ready is held high for the whole RECV phase.
module layer_stream_host
    import layer_stream_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 3,
    parameter int T = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N*T-1:0] vec_in,
    output logic           busy,
    output logic           done,
    output logic [M*T-1:0] result,
    output logic           tx_valid,
    output logic [T-1:0]   tx_data,
    input  logic           tx_ready,
    input  logic           rx_valid,
    input  logic [T-1:0]   rx_data,
    output logic           rx_ready
);

    localparam int TXW = idx_width(N);
    localparam int RXW = idx_width(M);

    state_t         state_reg;
    logic [T-1:0]   vec_words [N];
    logic [T-1:0]   shadow_reg [N];
    logic [TXW-1:0] tx_idx;
    logic [TXW-1:0] tx_idx_next;
    logic [T-1:0]   tx_word_next;
    logic           tx_last;
    logic [RXW-1:0] rx_idx;
    logic           rx_last;
    logic           start_accept;
    logic           tx_fire;
    logic           rx_fire;

    // Split the flat input vector into words.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_vec_words
            assign vec_words[gi] = vec_in[gi*T +: T];
        end
    endgenerate

    assign start_accept = (state_reg == IDLE) && start;
    assign tx_fire      = (state_reg == SEND) && tx_valid && tx_ready;
    assign rx_fire      = (state_reg == RECV) && rx_valid && rx_ready;

    stream_word_counter #(.K(N), .W(TXW)) u_tx_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (start_accept),
        .inc   (tx_fire),
        .idx   (tx_idx),
        .last  (tx_last)
    );

    stream_word_counter #(.K(M), .W(RXW)) u_rx_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (start_accept),
        .inc   (rx_fire),
        .idx   (rx_idx),
        .last  (rx_last)
    );

    // Shadow copy of the vector so later changes on vec_in cannot disturb the send.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                shadow_reg[k] <= '0;
            end
        end else if (start_accept) begin
            shadow_reg <= vec_words;
        end
    end

    // Word to present after the current one is accepted; out-of-range index yields 0.
    always_comb begin
        tx_idx_next  = tx_idx + TXW'(1);
        tx_word_next = '0;
        for (int k = 0; k < N; k++) begin
            if (tx_idx_next == TXW'(k)) begin
                tx_word_next = shadow_reg[k];
            end
        end
    end

    // Transaction sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            rx_ready  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= SEND;
                        busy      <= 1'b1;
                        tx_valid  <= 1'b1;
                        tx_data   <= vec_words[0];
                    end
                end
                SEND: begin
                    if (tx_fire) begin
                        if (tx_last) begin
                            tx_valid  <= 1'b0;
                            state_reg <= RECV;
`ifdef LAYER_STREAM_HOST_RX_THROTTLE_EN
                            rx_ready  <= 1'b0;
`else
                            rx_ready  <= 1'b1;
`endif
                        end else begin
                            tx_data <= tx_word_next;
                        end
                    end
                end
                RECV: begin
                    if (rx_last) begin
                        rx_ready  <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
`ifdef LAYER_STREAM_HOST_RX_THROTTLE_EN
                        rx_ready <= ~rx_ready;
`else
                        rx_ready <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Result words: each slot is overwritten only when its index is received.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_result
            logic [T-1:0] word_reg;

            // Capture slot gi on its receive transfer; hold otherwise.
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (rx_fire && (rx_idx == RXW'(gi))) begin
                    word_reg <= rx_data;
                end
            end

            assign result[gi*T +: T] = word_reg;
        end
    endgenerate

endmodule

// File: tb/tb_layer_stream_host.sv
// Self-checking bench for layer_stream_host: queue-based transaction model
// compared every cycle, plus directed literal checks of the key scenarios.
module tb_layer_stream_host;

    localparam int N = 3;
    localparam int M = 3;
    localparam int T = 8;
`ifdef LAYER_STREAM_HOST_RX_THROTTLE_EN
    localparam bit THROTTLE = 1'b1;
`else
    localparam bit THROTTLE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [N*T-1:0] vec_in = '0;
    logic           busy;
    logic           done;
    logic [M*T-1:0] result;
    logic           tx_valid;
    logic [T-1:0]   tx_data;
    logic           tx_ready = 1'b0;
    logic           rx_valid = 1'b0;
    logic [T-1:0]   rx_data = '0;
    logic           rx_ready;

    int total = 0;
    int bad   = 0;

    layer_stream_host #(.N(N), .M(M), .T(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .vec_in   (vec_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 sending, 2 receiving, 3 done pulse
    int           m_phase = 0;
    logic [T-1:0] m_q[$];
    int           m_rxk = 0;
    bit           m_live = 1'b0;
    logic         e_busy = 0, e_done = 0, e_txv = 0, e_rxr = 0;
    logic [T-1:0] e_txd = '0;
    logic [T-1:0] e_res [M];

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_q.delete();
            m_rxk  = 0;
            e_busy = 0; e_done = 0; e_txv = 0; e_rxr = 0; e_txd = '0;
            for (int k = 0; k < M; k++) e_res[k] = '0;
            m_live = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    e_done = 0;
                    if (start) begin
                        m_q.delete();
                        for (int k = 0; k < N; k++) m_q.push_back(vec_in[k*T +: T]);
                        e_busy = 1; e_txv = 1; e_txd = m_q[0];
                        m_rxk = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (tx_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) begin
                            e_txv = 0;
                            e_rxr = !THROTTLE;
                            m_phase = 2;
                        end else begin
                            e_txd = m_q[0];
                        end
                    end
                end
                2: begin
                    if (rx_valid && e_rxr) begin
                        e_res[m_rxk] = rx_data;
                        m_rxk++;
                    end
                    if (m_rxk == M) begin
                        e_rxr = 0; e_done = 1; m_phase = 3;
                    end else if (THROTTLE) begin
                        e_rxr = !e_rxr;
                    end
                end
                default: begin
                    e_done = 0; e_busy = 0; m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- compare + monitors ----------------
    logic [T-1:0] tx_log[$];
    bit           rx_pat_q[$];
    bit           rec_rx = 1'b0;
    int           cnt02 = 0;

    always @(negedge clk) begin
        if (m_live) begin
            logic [M*T-1:0] exp_res;
            for (int k = 0; k < M; k++) exp_res[k*T +: T] = e_res[k];
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("tx_valid", tx_valid, e_txv);
            if (e_txv) check("tx_data", tx_data, e_txd);
            check("rx_ready", rx_ready, e_rxr);
            check("result", result, exp_res);
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            if (tx_valid && tx_data == 8'h02) cnt02++;
            if (rec_rx && m_phase == 2) rx_pat_q.push_back(rx_ready);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input int n);
        int c = 0;
        while (tx_log.size() < n && c < 50) begin
            tick();
            c++;
        end
        check("tx_wait", (tx_log.size() >= n), 1);
    endtask

    task automatic rx_word(input logic [T-1:0] w);
        bit ok = 0;
        rx_valid = 1'b1;
        rx_data  = w;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1;
                break;
            end
        end
        tick();
        check("rx_handshake", ok, 1);
        rx_valid = 1'b0;
    endtask

    task automatic rx_send(input logic [T-1:0] w0, input logic [T-1:0] w1, input logic [T-1:0] w2);
        rx_word(w0);
        rx_word(w1);
        rx_word(w2);
    endtask

    function automatic logic [N*T-1:0] log_word3();
        return {tx_log[2], tx_log[1], tx_log[0]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] plen;

        tick(); tick();
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);
        check("reset_tx_valid", tx_valid, 0);

        // basic send + receive
        tx_log.delete(); rx_pat_q.delete(); rec_rx = 1;
        vec_in = 24'h030201; start = 1; tx_ready = 1;
        tick();
        start = 0;
        check("t1_first_valid", tx_valid, 1);
        check("t1_word0", tx_data, 8'h01);
        check("t1_busy", busy, 1);
        wait_tx(3);
        check("t1_tx_seq", log_word3(), 24'h030201);
        check("t1_tx_valid_off", tx_valid, 0);
        tx_ready = 0;
        rx_send(8'h07, 8'h00, 8'h05);
        rec_rx = 0;
        check("t1_done", done, 1);
        check("t1_result", result, 24'h050007);
        pat = 0;
        foreach (rx_pat_q[i]) pat = {pat[6:0], rx_pat_q[i]};
        plen = 8'(rx_pat_q.size());
        check("t1_rx_ready_pattern", {plen, pat}, THROTTLE ? 16'h0615 : 16'h0307);
        tick();
        check("t1_done_off", done, 0);
        check("t1_busy_off", busy, 0);

        // back-pressure, ignored start and early rx
        tx_log.delete(); cnt02 = 0;
        vec_in = 24'h030201; start = 1; tx_ready = 1;
        tick();
        start = 0;
        tick();
        tx_ready = 0; rx_valid = 1; rx_data = 8'hAA;
        start = 1; vec_in = 24'h999999;
        tick();
        start = 0;
        tick();
        check("t2_rx_ready_send", rx_ready, 0);
        check("t2_result_hold", result, 24'h050007);
        check("t2_word1_held", tx_data, 8'h02);
        tx_ready = 1; rx_valid = 0;
        wait_tx(3);
        check("t2_tx_seq", log_word3(), 24'h030201);
        check("t2_word1_cycles", cnt02, 3);
        tx_ready = 0;
        rx_send(8'h11, 8'h22, 8'h33);
        check("t2_result", result, 24'h332211);
        tick();

        // reset mid-SEND, then a fresh transaction
        tx_log.delete();
        vec_in = 24'h030201; start = 1; tx_ready = 1;
        tick();
        start = 0;
        tick();
        tx_ready = 0; reset = 1;
        tick();
        reset = 0;
        check("t3_tx_valid", tx_valid, 0);
        check("t3_busy", busy, 0);
        check("t3_result", result, 0);
        check("t3_sent_before_reset", tx_log.size(), 1);
        tx_log.delete();
        vec_in = 24'h0C0B0A; start = 1; tx_ready = 1;
        tick();
        start = 0;
        wait_tx(3);
        check("t3_tx_seq", log_word3(), 24'h0C0B0A);
        tx_ready = 0;
        rx_send(8'h01, 8'h02, 8'h03);
        check("t3_result", result, 24'h030201);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
